// File: rtl/crc8_smbus_pkg.sv
// CRC-8 helpers for the byte-wide frame path.
// Polynomial x^8+x^7+x^4+x^3+x+1 (0x9B), MSB first, init 0xFF.
package crc8_smbus_pkg;

   localparam logic [7:0] CRC8_POLY    = 8'h9B;
   localparam logic [7:0] CRC8_INIT    = 8'hFF;
   localparam logic [7:0] CRC8_RESIDUE = 8'h00;

   // Only crc^data matters, so a matching CRC byte always leaves a zero residue.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] v;
      v = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         v = v[7] ? ({v[6:0], 1'b0} ^ CRC8_POLY) : {v[6:0], 1'b0};
      end
      return v;
   endfunction

endpackage

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 framer: strips the trailing CRC byte, forwards payload
// with m_last on the final payload byte and reports per-frame status.
module crc8_frame_checker
   import crc8_smbus_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [7:0]       m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic             frame_done,
   output logic             frame_ok,
   output logic [LEN_W-1:0] frame_len,
   output logic             err_short,
   output logic             err_overlen
);

   localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] CNT_SAT   = '1;

   logic [7:0]       crc;
   logic [7:0]       crc_nxt;
   logic [7:0]       hold_data;
   logic             hold_valid;
   logic [LEN_W-1:0] cnt;
   logic             acc;
   logic             out_free;
   logic             over;

   assign out_free = !m_valid || m_ready;
   assign s_ready  = !hold_valid || out_free;
   assign acc      = s_valid && s_ready;
   assign crc_nxt  = crc8_next(crc, s_data);
   assign over     = cnt > MAX_LEN_W;

   // A byte waits in the hold register until the next accept tells us whether
   // it was the last payload byte; the CRC byte itself is never forwarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc         <= CRC8_INIT;
         hold_data   <= 8'h00;
         hold_valid  <= 1'b0;
         cnt         <= '0;
         m_data      <= 8'h00;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         frame_done  <= 1'b0;
         frame_ok    <= 1'b0;
         frame_len   <= '0;
         err_short   <= 1'b0;
         err_overlen <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (acc) begin
            if (hold_valid) begin
               m_data  <= hold_data;
               m_last  <= s_last;
               m_valid <= 1'b1;
            end
            if (s_last) begin
               crc         <= CRC8_INIT;
               hold_valid  <= 1'b0;
               cnt         <= '0;
               frame_done  <= 1'b1;
               frame_len   <= cnt;
               err_short   <= !hold_valid;
               err_overlen <= over;
               frame_ok    <= (crc_nxt == CRC8_RESIDUE) && hold_valid && !over;
            end else begin
               crc        <= crc_nxt;
               hold_data  <= s_data;
               hold_valid <= 1'b1;
               if (cnt != CNT_SAT) begin
                  cnt <= cnt + LEN_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker; CRC bytes below are hand-computed
// for polynomial 0x9B, init 0xFF.
module tb_crc8_frame_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;
   logic       frame_done;
   logic       frame_ok;
   logic [7:0] frame_len;
   logic       err_short;
   logic       err_overlen;

   int check_count = 0;
   int fail_count  = 0;

   logic [7:0] out_data[$];
   logic       out_last[$];
   int         done_count;
   logic       done_ok;
   logic       done_short;
   logic       done_over;
   logic       done_with_last;
   logic [7:0] done_len;
   logic       saw_ready_low;

   crc8_frame_checker #(.MAX_LEN(64), .LEN_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .frame_done (frame_done),
      .frame_ok   (frame_ok),
      .frame_len  (frame_len),
      .err_short  (err_short),
      .err_overlen(err_overlen)
   );

   always #5 clk = ~clk;

   // Handshakes complete on the next rising edge, so sampling them mid-cycle is safe.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            out_data.push_back(m_data);
            out_last.push_back(m_last);
         end
         if (frame_done) begin
            done_count++;
            done_ok        = frame_ok;
            done_short     = err_short;
            done_over      = err_overlen;
            done_len       = frame_len;
            done_with_last = m_valid && m_last;
         end
         if (s_valid && !s_ready) saw_ready_low = 1'b1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic last);
      bit got = 1'b0;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = last;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) checkOutput("accept_timeout", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic clearScoreboard();
      out_data.delete();
      out_last.delete();
      done_count    = 0;
      saw_ready_low = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int bad;
      int last_cnt;
      logic [3:0] last_pat;

      rst_n   = 1'b0;
      s_data  = 8'h00;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      clearScoreboard();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_m_valid",     32'(m_valid),     32'd0);
      checkOutput("rst_m_last",      32'(m_last),      32'd0);
      checkOutput("rst_m_data",      32'(m_data),      32'h00);
      checkOutput("rst_frame_done",  32'(frame_done),  32'd0);
      checkOutput("rst_frame_ok",    32'(frame_ok),    32'd0);
      checkOutput("rst_frame_len",   32'(frame_len),   32'd0);
      checkOutput("rst_err_short",   32'(err_short),   32'd0);
      checkOutput("rst_err_overlen", 32'(err_overlen), 32'd0);
      checkOutput("rst_s_ready",     32'(s_ready),     32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Good one-byte frame: CRC of {0x00} is 0x7B.
      clearScoreboard();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h7B, 1'b1);
      settle();
      checkOutput("t1_count",     32'(out_data.size()), 32'd1);
      checkOutput("t1_data",      32'(out_data[0]),     32'h00);
      checkOutput("t1_last",      32'(out_last[0]),     32'd1);
      checkOutput("t1_done",      32'(done_count),      32'd1);
      checkOutput("t1_ok",        32'(done_ok),         32'd1);
      checkOutput("t1_len",       32'(done_len),        32'd1);
      checkOutput("t1_done_last", 32'(done_with_last),  32'd1);

      // Corrupted CRC byte.
      clearScoreboard();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h7C, 1'b1);
      settle();
      checkOutput("t2_count", 32'(out_data.size()), 32'd1);
      checkOutput("t2_data",  32'(out_data[0]),     32'h00);
      checkOutput("t2_last",  32'(out_last[0]),     32'd1);
      checkOutput("t2_ok",    32'(done_ok),         32'd0);
      checkOutput("t2_len",   32'(done_len),        32'd1);

      // CRC byte only.
      clearScoreboard();
      applyStimulus(8'h55, 1'b1);
      settle();
      checkOutput("t3_count", 32'(out_data.size()), 32'd0);
      checkOutput("t3_done",  32'(done_count),      32'd1);
      checkOutput("t3_short", 32'(done_short),      32'd1);
      checkOutput("t3_ok",    32'(done_ok),         32'd0);
      checkOutput("t3_len",   32'(done_len),        32'd0);

      // {01,02,03,04} has CRC 0x67; downstream stalls for 5 cycles at frame start.
      clearScoreboard();
      m_ready = 1'b0;
      fork
         begin
            applyStimulus(8'h01, 1'b0);
            applyStimulus(8'h02, 1'b0);
            applyStimulus(8'h03, 1'b0);
            applyStimulus(8'h04, 1'b0);
            applyStimulus(8'h67, 1'b1);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      settle();
      checkOutput("t4_ready_low", 32'(saw_ready_low),   32'd1);
      checkOutput("t4_count",     32'(out_data.size()), 32'd4);
      checkOutput("t4_data",
                  {out_data[0], out_data[1], out_data[2], out_data[3]}, 32'h01020304);
      last_pat = {out_last[0], out_last[1], out_last[2], out_last[3]};
      checkOutput("t4_last_pat",  32'(last_pat),        32'b0001);
      checkOutput("t4_ok",        32'(done_ok),         32'd1);
      checkOutput("t4_len",       32'(done_len),        32'd4);

      // 65 payload bytes exceed MAX_LEN=64.
      clearScoreboard();
      for (int i = 0; i < 65; i++) applyStimulus(8'(i), 1'b0);
      applyStimulus(8'h00, 1'b1);
      settle();
      checkOutput("t5_count", 32'(out_data.size()), 32'd65);
      bad = 0;
      last_cnt = 0;
      for (int i = 0; i < out_data.size(); i++) begin
         if (out_data[i] !== 8'(i)) bad++;
         if (out_last[i]) last_cnt++;
      end
      checkOutput("t5_order",   32'(bad),        32'd0);
      checkOutput("t5_lastcnt", 32'(last_cnt),   32'd1);
      checkOutput("t5_overlen", 32'(done_over),  32'd1);
      checkOutput("t5_len",     32'(done_len),   32'd65);
      checkOutput("t5_ok",      32'(done_ok),    32'd0);

      // Reset after two payload bytes, then a clean frame.
      clearScoreboard();
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'hBB, 1'b0);
      rst_n   = 1'b0;
      s_valid = 1'b0;
      #2;
      checkOutput("t6_rst_m_valid", 32'(m_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t6_partial_out",  32'(out_data.size()), 32'd0);
      checkOutput("t6_partial_done", 32'(done_count),      32'd0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h7B, 1'b1);
      settle();
      checkOutput("t6_count", 32'(out_data.size()), 32'd1);
      checkOutput("t6_data",  32'(out_data[0]),     32'h00);
      checkOutput("t6_ok",    32'(done_ok),         32'd1);
      checkOutput("t6_len",   32'(done_len),        32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
